// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one sram_like slave port between an instruction-side master (m0) and a
//   data-side master (m1). The grant is held from request until data_ok, so only one
//   transaction is ever outstanding at the slave. Added latency is zero: the request
//   reaches the slave in the cycle it is presented, and addr_ok/data_ok are
//   combinational pass-throughs to the owning master.
//
// Parameters
//   RR  1 = round-robin on a tie, 0 = fixed priority with m1 winning.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   mX_req/wr/size/addr/wdata   request fields from master X (X = 0 instr, 1 data)
//   mX_rdata                    read data (s_rdata for both masters)
//   mX_addr_ok, mX_data_ok      handshakes, raised only for the current owner
//   s_req/wr/size/addr/wdata    request fields toward the slave
//   s_rdata, s_addr_ok, s_data_ok  slave responses
module sram_like_arbiter #(
  parameter int unsigned RR = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,

  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,

  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;

  logic any_req;
  logic sel;
  logic grant;
  logic req_raw;
  logic addr_hit;
  logic data_hit;

  assign any_req = m0_req | m1_req;

  // Tie-break: round-robin picks the master that did not win last time.
  always_comb begin
    sel = 1'b0;
    if (m0_req && m1_req) begin
      sel = (RR != 0) ? ~last_q : 1'b1;
    end else if (m1_req) begin
      sel = 1'b1;
    end
  end

  // Live selection only in IDLE; afterwards the grant is locked to the owner.
  assign grant = (state_q == StIdle) ? sel : owner_q;

  always_comb begin
    req_raw  = 1'b0;
    addr_hit = 1'b0;
    data_hit = 1'b0;
    case (state_q)
      StIdle: begin
        req_raw  = any_req;
        addr_hit = any_req & s_addr_ok;
      end
      StAddr: begin
        req_raw  = owner_q ? m1_req : m0_req;
        addr_hit = s_addr_ok;
      end
      StData: begin
        data_hit = s_data_ok;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = sel;
          if (s_addr_ok) begin
            last_d  = sel;
            state_d = StData;
          end else begin
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (s_addr_ok) begin
          last_d  = owner_q;
          state_d = StData;
        end
      end
      StData: begin
        if (s_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // last resets to 1 so that m0 wins the first round-robin tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Handshakes are gated by reset so they drop the instant rst falls, even while a
  // master is still holding req.
  assign s_req      = req_raw & rst;
  assign m0_addr_ok = addr_hit & ~grant & rst;
  assign m1_addr_ok = addr_hit & grant & rst;
  assign m0_data_ok = data_hit & ~owner_q & rst;
  assign m1_data_ok = data_hit & owner_q & rst;

  assign s_wr    = grant ? m1_wr    : m0_wr;
  assign s_size  = grant ? m1_size  : m0_size;
  assign s_addr  = grant ? m1_addr  : m0_addr;
  assign s_wdata = grant ? m1_wdata : m0_wdata;

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter. Two instances share every input: index 0 is built
// round-robin, index 1 fixed priority. A transaction-level model (who holds the port,
// whether its address was accepted, who won last) predicts every output each cycle;
// directed scenarios add literal expectations at the interesting cycles.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] s_rdata;
  logic        s_addr_ok, s_data_ok;

  logic [31:0] a_m0_rdata [2];
  logic [31:0] a_m1_rdata [2];
  logic [31:0] a_s_addr   [2];
  logic [31:0] a_s_wdata  [2];
  logic [1:0]  a_s_size   [2];
  logic [1:0]  a_m0_aok, a_m0_dok, a_m1_aok, a_m1_dok, a_s_req, a_s_wr;

  int nvec  = 0;
  int nmiss = 0;
  bit run   = 1'b0;

  sram_like_arbiter #(.RR(1)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(a_m0_rdata[0]), .m0_addr_ok(a_m0_aok[0]),
    .m0_data_ok(a_m0_dok[0]),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(a_m1_rdata[0]), .m1_addr_ok(a_m1_aok[0]),
    .m1_data_ok(a_m1_dok[0]),
    .s_req(a_s_req[0]), .s_wr(a_s_wr[0]), .s_size(a_s_size[0]), .s_addr(a_s_addr[0]),
    .s_wdata(a_s_wdata[0]), .s_rdata(s_rdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok)
  );

  sram_like_arbiter #(.RR(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(a_m0_rdata[1]), .m0_addr_ok(a_m0_aok[1]),
    .m0_data_ok(a_m0_dok[1]),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(a_m1_rdata[1]), .m1_addr_ok(a_m1_aok[1]),
    .m1_data_ok(a_m1_dok[1]),
    .s_req(a_s_req[1]), .s_wr(a_s_wr[1]), .s_size(a_s_size[1]), .s_addr(a_s_addr[1]),
    .s_wdata(a_s_wdata[1]), .s_rdata(s_rdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // hold: -1 when the port is free, else the master owning the transaction.
  int hold  [2];
  int lastg [2];
  bit acc   [2];

  function automatic int pick(int k);
    if (m0_req && m1_req) return (k == 0) ? 1 - lastg[k] : 1;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  function automatic int who(int k);
    return (hold[k] < 0) ? pick(k) : hold[k];
  endfunction

  function automatic bit exp_aok(int k);
    return rst && s_addr_ok && ((hold[k] < 0 && pick(k) >= 0) || (hold[k] >= 0 && !acc[k]));
  endfunction

  function automatic bit exp_dok(int k);
    return rst && s_data_ok && hold[k] >= 0 && acc[k];
  endfunction

  function automatic bit exp_sreq(int k);
    if (!rst) return 1'b0;
    if (hold[k] < 0) return pick(k) >= 0;
    if (acc[k]) return 1'b0;
    return (hold[k] == 1) ? m1_req : m0_req;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        hold[k]  <= -1;
        acc[k]   <= 1'b0;
        lastg[k] <= 1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (hold[k] < 0) begin
          if (pick(k) >= 0) begin
            hold[k] <= pick(k);
            acc[k]  <= s_addr_ok;
            if (s_addr_ok) lastg[k] <= pick(k);
          end
        end else if (!acc[k]) begin
          if (s_addr_ok) begin
            acc[k]   <= 1'b1;
            lastg[k] <= hold[k];
          end
        end else if (s_data_ok) begin
          hold[k] <= -1;
          acc[k]  <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        int w;
        w = who(k);
        chk($sformatf("k%0d s_req", k), {31'd0, a_s_req[k]}, {31'd0, exp_sreq(k)});
        chk($sformatf("k%0d m0_addr_ok", k), {31'd0, a_m0_aok[k]},
            {31'd0, exp_aok(k) && w == 0});
        chk($sformatf("k%0d m1_addr_ok", k), {31'd0, a_m1_aok[k]},
            {31'd0, exp_aok(k) && w == 1});
        chk($sformatf("k%0d m0_data_ok", k), {31'd0, a_m0_dok[k]},
            {31'd0, exp_dok(k) && hold[k] == 0});
        chk($sformatf("k%0d m1_data_ok", k), {31'd0, a_m1_dok[k]},
            {31'd0, exp_dok(k) && hold[k] == 1});
        chk($sformatf("k%0d m0_rdata", k), a_m0_rdata[k], s_rdata);
        chk($sformatf("k%0d m1_rdata", k), a_m1_rdata[k], s_rdata);
        if (rst && w >= 0) begin
          chk($sformatf("k%0d s_addr", k), a_s_addr[k], (w == 1) ? m1_addr : m0_addr);
          chk($sformatf("k%0d s_wdata", k), a_s_wdata[k], (w == 1) ? m1_wdata : m0_wdata);
          chk($sformatf("k%0d s_wr", k), {31'd0, a_s_wr[k]},
              {31'd0, (w == 1) ? m1_wr : m0_wr});
          chk($sformatf("k%0d s_size", k), {30'd0, a_s_size[k]},
              {30'd0, (w == 1) ? m1_size : m0_size});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  function automatic int granted(int k);
    if (a_m0_aok[k]) return 0;
    if (a_m1_aok[k]) return 1;
    return 9;
  endfunction

  int exp_rr [5] = '{0, 1, 0, 1, 0};
  int exp_fp [5] = '{1, 1, 1, 1, 0};
  logic [31:0] exp_rr_addr [5] = '{32'hA000, 32'hB000, 32'hA000, 32'hB000, 32'hA000};

  initial begin
    rst = 1'b0;
    m0_req = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
    s_rdata = 0; s_addr_ok = 0; s_data_ok = 0;

    // Handshakes stay quiet during reset even with a live request.
    #2;
    m0_req = 1; s_addr_ok = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst k%0d s_req", k), {31'd0, a_s_req[k]}, 32'd0);
      chk($sformatf("rst k%0d m0_addr_ok", k), {31'd0, a_m0_aok[k]}, 32'd0);
    end
    m0_req = 0; s_addr_ok = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run = 1'b1;

    // Single read, m0 only.
    next_cycle();
    m0_req = 1; m0_addr = 32'h1000; s_addr_ok = 1;
    settle();
    chk("t1 m0_addr_ok c0", {31'd0, a_m0_aok[0]}, 32'd1);
    chk("t1 s_addr c0", a_s_addr[0], 32'h1000);
    next_cycle();
    m0_req = 0; s_addr_ok = 0;
    settle();
    chk("t1 m0_data_ok c1", {31'd0, a_m0_dok[0]}, 32'd0);
    next_cycle();
    s_data_ok = 1; s_rdata = 32'hDEADBEEF;
    settle();
    chk("t1 m0_data_ok c2", {31'd0, a_m0_dok[0]}, 32'd1);
    chk("t1 m0_rdata c2", a_m0_rdata[0], 32'hDEADBEEF);
    chk("t1 m1_data_ok c2", {31'd0, a_m1_dok[0]}, 32'd0);
    next_cycle();
    s_data_ok = 0;

    // Ties: RR alternates from m0, fixed priority always m1 until m1 drops.
    do_reset();
    m0_addr = 32'hA000; m1_addr = 32'hB000;
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) m1_req = 0;
      next_cycle();
      s_addr_ok = 1; s_data_ok = 0;
      settle();
      chk($sformatf("rr grant %0d", i), granted(0), exp_rr[i]);
      chk($sformatf("fp grant %0d", i), granted(1), exp_fp[i]);
      chk($sformatf("rr s_addr %0d", i), a_s_addr[0], exp_rr_addr[i]);
      next_cycle();
      s_addr_ok = 0; s_data_ok = 1;
      settle();
    end
    next_cycle();
    m0_req = 0; m1_req = 0; s_data_ok = 0;

    // Address phase lock while the slave withholds addr_ok.
    next_cycle();
    m0_addr = 32'hC000; m1_addr = 32'hD000; m0_req = 1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) m1_req = 1;
      if (c == 3) s_addr_ok = 1;
      settle();
      chk($sformatf("t4 rr s_addr c%0d", c), a_s_addr[0], 32'hC000);
      chk($sformatf("t4 fp s_addr c%0d", c), a_s_addr[1], 32'hC000);
      chk($sformatf("t4 fp m1_addr_ok c%0d", c), {31'd0, a_m1_aok[1]}, 32'd0);
      next_cycle();
    end
    m0_req = 0; s_addr_ok = 0;
    settle();
    next_cycle();
    s_data_ok = 1;
    settle();
    chk("t4 m0_data_ok", {31'd0, a_m0_dok[1]}, 32'd1);
    next_cycle();
    s_data_ok = 0; s_addr_ok = 1;
    settle();
    chk("t4 fp s_addr m1", a_s_addr[1], 32'hD000);
    chk("t4 fp m1_addr_ok", {31'd0, a_m1_aok[1]}, 32'd1);
    next_cycle();
    m1_req = 0; s_addr_ok = 0;
    next_cycle();
    s_data_ok = 1;
    next_cycle();
    s_data_ok = 0;

    // Write with a stalled data phase; m0 requesting meanwhile must not leak out.
    next_cycle();
    m1_req = 1; m1_wr = 1; m1_size = 2'd2; m1_addr = 32'hE000; m1_wdata = 32'h12345678;
    s_addr_ok = 1;
    settle();
    chk("t5 s_wr", {31'd0, a_s_wr[0]}, 32'd1);
    chk("t5 s_wdata", a_s_wdata[0], 32'h12345678);
    chk("t5 s_size", {30'd0, a_s_size[0]}, 32'd2);
    chk("t5 m1_addr_ok", {31'd0, a_m1_aok[0]}, 32'd1);
    for (int j = 1; j <= 5; j++) begin
      next_cycle();
      m1_req = 0; s_addr_ok = 0;
      m0_req = (j >= 2 && j <= 4);
      s_data_ok = (j == 5);
      settle();
      chk($sformatf("t5 rr s_req d%0d", j), {31'd0, a_s_req[0]}, 32'd0);
      chk($sformatf("t5 fp s_req d%0d", j), {31'd0, a_s_req[1]}, 32'd0);
    end
    chk("t5 m1_data_ok", {31'd0, a_m1_dok[0]}, 32'd1);
    next_cycle();
    s_data_ok = 0; m1_wr = 0; m1_size = 0;

    // Reset in the middle of the data phase.
    next_cycle();
    m0_req = 1; m0_addr = 32'hF000; s_addr_ok = 1;
    settle();
    next_cycle();
    m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
    #1;
    chk("t6 m0_data_ok before rst", {31'd0, a_m0_dok[0]}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t6 k%0d m0_data_ok in rst", k), {31'd0, a_m0_dok[k]}, 32'd0);
      chk($sformatf("t6 k%0d s_req in rst", k), {31'd0, a_s_req[k]}, 32'd0);
    end
    next_cycle();
    rst = 1'b1;
    settle();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t6 k%0d m0_data_ok after", k), {31'd0, a_m0_dok[k]}, 32'd0);
      chk($sformatf("t6 k%0d m1_data_ok after", k), {31'd0, a_m1_dok[k]}, 32'd0);
    end
    next_cycle();
    s_data_ok = 0;
    settle();
    run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
